pc_fetch_redirect_unit: RTL and testbench

Instruction-fetch front end and PC owner for the 5-stage RISC-V pipeline. It is the consumer of the EX-stage branch/jump redirect (target PC plus taken flag). It fetches through a busywait-handshake instruction memory, holds the IF/ID register and flushes wrong-path instructions when a redirect arrives. It also absorbs hazard stalls with a one-entry hold buffer and counts taken redirects for performance monitoring.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_hold_buffer.sv | 49 ++++
 rtl/pc_fetch_redirect_unit.sv | 181 ++++++++++++++++++
 tb/tb_pc_fetch_redirect_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e   : FETCH (request outstanding), HOLD (instruction parked
//                     while ID is stalled), DROP (finishing a wrong-path access)
//   NOP_INSTR       : canonical RISC-V NOP (addi x0, x0, 0) used to kill IF/ID
//   PC_STEP_DEFAULT : sequential PC increment
//   align_pc()      : clears the two low bits of a redirect target
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register for a fetched {pc, instr} pair that could not be
// handed to ID because of a stall.
// Ports:
//   clk, rst_n        : clock, async active-low reset (clears valid only)
//   load              : capture pc_in/instr_in, mark valid
//   drain             : entry consumed into IF/ID, mark empty
//   clear             : entry discarded by a redirect, mark empty
//   pc_in, instr_in   : pair to capture
//   valid, pc, instr  : current entry
module fetch_hold_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (clear || drain) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
        end
    end

    // Payload is meaningless while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            r_pc    <= pc_in;
            r_instr <= instr_in;
        end
    end

    assign valid = r_valid;
    assign pc    = r_pc;
    assign instr = r_instr;

endmodule

// File: rtl/pc_fetch_redirect_unit.sv
// Instruction-fetch front end and PC owner for the 5-stage pipeline.
// Fetches through a busywait-handshake memory, owns the IF/ID register,
// squashes wrong-path fetches on an EX redirect and parks a fetched
// instruction in a one-entry buffer while ID is stalled.
// Ports:
//   CLK, RESET_N                  : clock, async active-low reset
//   redirect_valid, redirect_pc   : taken branch/jump target from EX
//   stall                         : ID cannot accept, IF/ID holds
//   imem_req, imem_addr           : fetch request/address
//   imem_rdata, imem_busywait     : fetch data, memory-not-ready
//   ifid_valid/pc/instr           : IF/ID register
//   flush_idex                    : kills the ID->EX transfer on redirect
//   redirect_count                : cycles with redirect_valid high (wraps)
module pc_fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_busywait,
    output logic             ifid_valid,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             flush_idex,
    output logic [CNT_W-1:0] redirect_count
);

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pend_pc;
    logic             r_ifid_valid;
    logic [31:0]      r_ifid_pc;
    logic [31:0]      r_ifid_instr;
    logic [CNT_W-1:0] r_cnt;

    logic        w_req_state;
    logic        w_done;
    logic [31:0] w_redir_pc;
    logic        w_ifid_load_mem;
    logic        w_hold_load;
    logic        w_hold_drain;
    logic        w_hold_clear;
    logic        w_hold_valid;
    logic [31:0] w_hold_pc;
    logic [31:0] w_hold_instr;

    // Request is suppressed while reset is asserted so an in-flight access is
    // abandoned immediately rather than at the next edge.
    assign imem_req   = RESET_N & w_req_state;
    assign imem_addr  = r_pc;
    assign w_done     = imem_req & ~imem_busywait;
    assign w_redir_pc = align_pc(redirect_pc);

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (redirect_valid && !w_done)
                    w_next_state = DROP;
                else if (!redirect_valid && w_done && stall)
                    w_next_state = HOLD;
            end
            HOLD: begin
                if (redirect_valid || !stall)
                    w_next_state = FETCH;
            end
            DROP: begin
                if (w_done)
                    w_next_state = FETCH;
            end
            default: w_next_state = FETCH;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        w_req_state     = (r_state != HOLD);
        w_ifid_load_mem = (r_state == FETCH) && !redirect_valid && w_done && !stall;
        w_hold_load     = (r_state == FETCH) && !redirect_valid && w_done && stall;
        w_hold_drain    = (r_state == HOLD) && !redirect_valid && !stall && w_hold_valid;
        w_hold_clear    = (r_state == HOLD) && redirect_valid;
    end

    // PC and pending-redirect target. In DROP the PC is frozen so the memory
    // sees a stable address until the abandoned access completes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc      <= RESET_PC;
            r_pend_pc <= 32'h0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (redirect_valid) begin
                        if (w_done) r_pc      <= w_redir_pc;
                        else        r_pend_pc <= w_redir_pc;
                    end else if (w_done) begin
                        r_pc <= r_pc + PC_STEP;
                    end
                end
                HOLD: begin
                    if (redirect_valid) r_pc <= w_redir_pc;
                end
                DROP: begin
                    if (w_done)
                        r_pc <= redirect_valid ? w_redir_pc : r_pend_pc;
                    else if (redirect_valid)
                        r_pend_pc <= w_redir_pc;
                end
                default: ;
            endcase
        end
    end

    // IF/ID register: redirect beats stall beats load.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'h0;
            r_ifid_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end else if (w_ifid_load_mem) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= imem_rdata;
        end else if (w_hold_drain) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= w_hold_pc;
            r_ifid_instr <= w_hold_instr;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (redirect_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    fetch_hold_buffer u_hold (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .load     (w_hold_load),
        .drain    (w_hold_drain),
        .clear    (w_hold_clear),
        .pc_in    (r_pc),
        .instr_in (imem_rdata),
        .valid    (w_hold_valid),
        .pc       (w_hold_pc),
        .instr    (w_hold_instr)
    );

    assign ifid_valid     = r_ifid_valid;
    assign ifid_pc        = r_ifid_pc;
    assign ifid_instr     = r_ifid_instr;
    assign flush_idex     = redirect_valid;
    assign redirect_count = r_cnt;

endmodule

// File: tb/tb_pc_fetch_redirect_unit.sv
module tb_pc_fetch_redirect_unit;

    logic        CLK;
    logic        RESET_N;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        flush_idex;
    logic [15:0] redirect_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [15:0] exp_cnt = 16'd0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    pc_fetch_redirect_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4),
        .CNT_W    (16)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_busywait  (imem_busywait),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .flush_idex     (flush_idex),
        .redirect_count (redirect_count)
    );

    // Memory model: instruction word is a function of its address.
    assign imem_rdata = ~imem_addr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected fetch result for an address
    function automatic logic [63:0] entry(input logic [31:0] pc);
        return {pc, ~pc};
    endfunction

    task automatic test_reset();
        RESET_N = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        stall = 1'b0; imem_busywait = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req act=%b exp=0", imem_req); end
        n_checks++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b0, 32'h0, NOP})
            begin n_fail++; $display("FAIL reset_ifid act=%b/%h/%h exp=0/0/%h", ifid_valid, ifid_pc, ifid_instr, NOP); end
        n_checks++;
        if (redirect_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt act=%0d exp=0", redirect_count); end
        step();
        step();
        RESET_N = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL reset_release act=%b/%h exp=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(entry(32'(i * 4)));
            step();
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL seq_sb empty"); end
            else begin
                e = exp_q.pop_front();
                if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
                    begin n_fail++; $display("FAIL seq_ifid act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
            end
        end
    endtask

    task automatic test_busywait();
        imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ifid_pc !== 32'h4)
                begin n_fail++; $display("FAIL bw_hold act=%b/%h/%h exp=1/8/4", imem_req, imem_addr, ifid_pc); end
        end
        imem_busywait = 1'b0;
        exp_q.push_back(entry(32'h8));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL bw_done act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        exp_q.push_back(entry(32'hC));
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b0 || ifid_pc !== 32'h8 || ifid_valid !== 1'b1)
                begin n_fail++; $display("FAIL stall_frozen act=%b/%h/%b exp=0/8/1", imem_req, ifid_pc, ifid_valid); end
        end
        stall = 1'b0;
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL stall_drain act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10)
            begin n_fail++; $display("FAIL stall_resume act=%b/%h exp=1/10", imem_req, imem_addr); end
        exp_q.push_back(entry(32'h10));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL stall_next act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
    endtask

    task automatic test_redirect_fetch();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        n_checks++;
        if (flush_idex !== 1'b1) begin n_fail++; $display("FAIL redir_flush act=%b exp=1", flush_idex); end
        exp_cnt++;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP || flush_idex !== 1'b0)
            begin n_fail++; $display("FAIL redir_kill act=%b/%h/%b exp=0/%h/0", ifid_valid, ifid_instr, flush_idex, NOP); end
        n_checks++;
        if (imem_addr !== 32'h100 || redirect_count !== exp_cnt)
            begin n_fail++; $display("FAIL redir_target act=%h/%0d exp=100/%0d", imem_addr, redirect_count, exp_cnt); end
        exp_q.push_back(entry(32'h100));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL redir_penalty act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
    endtask

    task automatic test_drop();
        imem_busywait = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        exp_cnt++;
        step();
        redirect_pc = 32'h300;
        exp_cnt++;
        #1;
        n_checks++;
        if (imem_addr !== 32'h104 || imem_req !== 1'b1 || ifid_valid !== 1'b0)
            begin n_fail++; $display("FAIL drop_hold act=%h/%b/%b exp=104/1/0", imem_addr, imem_req, ifid_valid); end
        step();
        redirect_valid = 1'b0;
        step();
        #1;
        n_checks++;
        if (imem_addr !== 32'h104 || imem_addr === 32'h200)
            begin n_fail++; $display("FAIL drop_addr act=%h exp=104", imem_addr); end
        imem_busywait = 1'b0;
        #1;
        step();
        n_checks++;
        if (imem_addr !== 32'h300 || ifid_valid !== 1'b0)
            begin n_fail++; $display("FAIL drop_done act=%h/%b exp=300/0", imem_addr, ifid_valid); end
        n_checks++;
        if (redirect_count !== exp_cnt) begin n_fail++; $display("FAIL drop_cnt act=%0d exp=%0d", redirect_count, exp_cnt); end
        exp_q.push_back(entry(32'h300));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL drop_fetch act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
    endtask

    task automatic test_hold_redirect();
        stall = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b0 || ifid_pc !== 32'h300)
            begin n_fail++; $display("FAIL hredir_hold act=%b/%h exp=0/300", imem_req, ifid_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        exp_cnt++;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        #1;
        n_checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 32'h400 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL hredir_kill act=%b/%h/%b exp=0/400/1", ifid_valid, imem_addr, imem_req); end
        exp_q.push_back(entry(32'h400));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL hredir_fetch act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1; redirect_pc = 32'h500; exp_cnt++;
        step();
        redirect_pc = 32'h602; exp_cnt++;
        step();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 32'h600 || ifid_valid !== 1'b0 || redirect_count !== exp_cnt)
            begin n_fail++; $display("FAIL b2b act=%h/%b/%0d exp=600/0/%0d", imem_addr, ifid_valid, redirect_count, exp_cnt); end
        exp_q.push_back(entry(32'h600));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL b2b_fetch act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; exp_cnt++;
        step();
        redirect_valid = 1'b0;
        exp_q.push_back(entry(32'hFFFF_FFFC));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e} || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL wrap act=%b/%h/%h addr=%h exp=1/%h addr=0", ifid_valid, ifid_pc, ifid_instr, imem_addr, e); end
    endtask

    task automatic test_reset_mid_drop();
        imem_busywait = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h700;
        step();
        redirect_valid = 1'b0;
        #2;
        RESET_N = 1'b0;
        exp_cnt = 16'd0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || redirect_count !== exp_cnt)
            begin n_fail++; $display("FAIL rst_drop_ctl act=%b/%h/%0d exp=0/0/0", imem_req, imem_addr, redirect_count); end
        n_checks++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b0, 32'h0, NOP})
            begin n_fail++; $display("FAIL rst_drop_ifid act=%b/%h/%h exp=0/0/%h", ifid_valid, ifid_pc, ifid_instr, NOP); end
        step();
        imem_busywait = 1'b0;
        RESET_N = 1'b1;
        exp_q.push_back(entry(32'h0));
        step();
        n_checks++;
        e = exp_q.pop_front();
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e})
            begin n_fail++; $display("FAIL rst_drop_fetch act=%b/%h/%h exp=1/%h", ifid_valid, ifid_pc, ifid_instr, e); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_busywait();
        test_stall();
        test_redirect_fetch();
        test_drop();
        test_hold_redirect();
        test_back_to_back();
        test_reset_mid_drop();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover act=%0d exp=0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
